// File: rtl/fwd_hazard_if.sv
// Bus between the pipeline control and fwd_hazard_unit: the EX/ID instruction
// fields the unit needs plus the bypass selects and stall it returns.
interface fwd_hazard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              flush;
  logic [SW-1:0]     fa;
  logic [SW-1:0]     fb;
  logic              stall;

  // Pipeline control side
  modport master (
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
    output id_valid, id_rs, id_rt, flush,
    input  fa, fb, stall
  );

  // Hazard unit side
  modport slave (
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
    input  id_valid, id_rs, id_rt, flush,
    output fa, fb, stall
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the pipelined MIPS core.
// Tracks destination tags of DEPTH in-flight instructions past EX, produces
// bypass selects for the EX operands and a stall request for ID.
// Optional feature macro: FWD_PERF_EN adds the saturating stall_cnt port.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  fwd_hazard_if.slave    bus
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);

  localparam int unsigned SW = $clog2(DEPTH + 1);

  // Tag pipeline: index k is stage k (1 = EX/MEM)
  logic              r_v  [1:DEPTH];
  logic [REG_AW-1:0] r_rd [1:DEPTH];
  logic              r_rw [1:DEPTH];
  logic              r_ld [1:DEPTH];

  logic              w_live [1:DEPTH];
  logic [SW-1:0]     w_fa;
  logic [SW-1:0]     w_fb;
  logic              w_fa_rdy;
  logic              w_fb_rdy;
  logic              w_ex_live;
  logic [1:0]        w_hz;
  logic [REG_AW-1:0] w_src;
  logic              w_hit;
  logic              w_ld;
  int                w_pos;
  logic              w_stall;

  // Shift tags down the pipeline; stage 1 captures the EX instruction unless flushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        r_v[k]  <= 1'b0;
        r_rd[k] <= '0;
        r_rw[k] <= 1'b0;
        r_ld[k] <= 1'b0;
      end
    end else begin
      r_v[1]  <= bus.ex_valid & ~bus.flush;
      r_rd[1] <= bus.ex_rd;
      r_rw[1] <= bus.ex_regwrite;
      r_ld[1] <= bus.ex_memread;
      for (int k = 2; k <= int'(DEPTH); k++) begin
        r_v[k]  <= r_v[k-1];
        r_rd[k] <= r_rd[k-1];
        r_rw[k] <= r_rw[k-1];
        r_ld[k] <= r_ld[k-1];
      end
    end
  end

  // A stage is a forwarding candidate only if it really writes a non-zero register
  always_comb begin
    for (int k = 1; k <= int'(DEPTH); k++) begin
      w_live[k] = r_v[k] & r_rw[k] & (r_rd[k] != '0);
    end
  end

  // Bypass selects: scan far-to-near so the nearest live match is kept
  always_comb begin
    w_fa     = '0;
    w_fb     = '0;
    w_fa_rdy = 1'b1;
    w_fb_rdy = 1'b1;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (w_live[k] && (r_rd[k] == bus.ex_rs)) begin
        w_fa     = SW'(k);
        w_fa_rdy = ~r_ld[k] | (k > int'(LOAD_LAT));
      end
      if (w_live[k] && (r_rd[k] == bus.ex_rt)) begin
        w_fb     = SW'(k);
        w_fb_rdy = ~r_ld[k] | (k > int'(LOAD_LAT));
      end
    end
    if (rst) begin
      w_fa = '0;
      w_fb = '0;
    end
  end

  // Load-use stall: ID sees EX-now at position 1 and stage k at position k+1 next cycle
  always_comb begin
    w_ex_live = bus.ex_valid & bus.ex_regwrite & (bus.ex_rd != '0);
    w_hz      = 2'b00;
    w_src     = '0;
    w_hit     = 1'b0;
    w_ld      = 1'b0;
    w_pos     = 0;
    for (int s = 0; s < 2; s++) begin
      w_src = (s == 0) ? bus.id_rs : bus.id_rt;
      w_hit = 1'b0;
      w_ld  = 1'b0;
      w_pos = 0;
      for (int k = int'(DEPTH); k >= 1; k--) begin
        if (w_live[k] && (r_rd[k] == w_src)) begin
          w_hit = 1'b1;
          w_ld  = r_ld[k];
          w_pos = k + 1;
        end
      end
      if (w_ex_live && (bus.ex_rd == w_src)) begin
        w_hit = 1'b1;
        w_ld  = bus.ex_memread;
        w_pos = 1;
      end
      w_hz[s] = (w_src != '0) & w_hit & w_ld & (w_pos < int'(LOAD_LAT) + 1);
    end
    w_stall = bus.id_valid & ~bus.flush & (|w_hz) & ~rst;
  end

  assign bus.fa    = w_fa;
  assign bus.fb    = w_fb;
  assign bus.stall = w_stall;

`ifdef FWD_PERF_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  // After a correct stall the selected producer must already hold forwardable data
  a_fwd_ready : assert property (@(posedge clk) disable iff (rst)
    (bus.ex_valid & ~bus.flush) |-> (w_fa_rdy & w_fb_rdy));

endmodule
